// File: rtl/rs232_tx_arbiter.sv
// Two-requester round-robin RS232 transmitter: one-entry holding register feeding an 8N1/8N2 shifter.
// Bit timing follows the clk_rs232_en baud tick; a byte held before stop time ends goes out back-to-back.
module rs232_tx_arbiter #(
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_rs232_en,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       active_src,
  output logic       frame_done
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic       hold_full_q, hold_full_d;
  logic       hold_src_q, hold_src_d;
  logic [7:0] hold_dat_q, hold_dat_d;
  logic       last_q, last_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d;
  logic       active_src_q, active_src_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;
  logic       grant0, grant1, start;

  // last_q names the requester granted most recently; the other one wins a tie.
  always_comb begin
    grant0 = rst && !hold_full_q && req0_valid && (!req1_valid || last_q);
    grant1 = rst && !hold_full_q && req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    hold_full_d  = hold_full_q;
    hold_src_d   = hold_src_q;
    hold_dat_d   = hold_dat_q;
    last_d       = last_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    tx_d         = tx_q;
    active_src_d = active_src_q;
    frame_done_d = 1'b0;
    start        = 1'b0;

    if (clk_rs232_en) begin
      unique case (state_q)
        IDLE: start = hold_full_q;
        DATA: begin
          if (bit_cnt_q < 4'd8) begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 2'd0;
            state_d    = STOP;
          end
        end
        STOP: begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end else begin
            frame_done_d = 1'b1;
            if (hold_full_q) begin
              start = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      tx_d         = 1'b0;
      shift_d      = hold_dat_q;
      active_src_d = hold_src_q;
      hold_full_d  = 1'b0;
      bit_cnt_d    = 4'd0;
      state_d      = DATA;
    end

    // A handshake needs an empty holding register, so it never collides with start.
    if (grant0 && req0_valid) begin
      hold_full_d = 1'b1;
      hold_dat_d  = req0_data;
      hold_src_d  = 1'b0;
      last_d      = 1'b0;
    end else if (grant1 && req1_valid) begin
      hold_full_d = 1'b1;
      hold_dat_d  = req1_data;
      hold_src_d  = 1'b1;
      last_d      = 1'b1;
    end

    busy_d = (state_d != IDLE) || hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      hold_full_q  <= 1'b0;
      hold_src_q   <= 1'b0;
      hold_dat_q   <= 8'h00;
      last_q       <= 1'b1;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      stop_cnt_q   <= 2'd0;
      tx_q         <= 1'b1;
      active_src_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_full_q  <= hold_full_d;
      hold_src_q   <= hold_src_d;
      hold_dat_q   <= hold_dat_d;
      last_q       <= last_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      active_src_q <= active_src_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: instance a uses one stop bit, instance b uses two.
// Inputs change and outputs are sampled 1 time unit after the rising clock edge.
module tb_rs232_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_rs232_en = 1'b0;

  logic       a_req0_valid = 1'b0, a_req1_valid = 1'b0;
  logic [7:0] a_req0_data = 8'h00, a_req1_data = 8'h00;
  logic       a_req0_ready, a_req1_ready, a_tx, a_busy, a_active_src, a_frame_done;

  logic       b_req0_valid = 1'b0, b_req1_valid = 1'b0;
  logic [7:0] b_req0_data = 8'h00, b_req1_data = 8'h00;
  logic       b_req0_ready, b_req1_ready, b_tx, b_busy, b_active_src, b_frame_done;

  int checks = 0;
  int errors = 0;
  int hs_limit = 1000;
  logic hs_q[$];

  always #5 clk = ~clk;

  rs232_tx_arbiter #(.STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .clk_rs232_en(clk_rs232_en),
    .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
    .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
    .tx(a_tx), .busy(a_busy), .active_src(a_active_src), .frame_done(a_frame_done)
  );

  rs232_tx_arbiter #(.STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .clk_rs232_en(clk_rs232_en),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .tx(b_tx), .busy(b_busy), .active_src(b_active_src), .frame_done(b_frame_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given tick level; logs instance-a handshakes taken at that edge.
  task automatic cyc(input logic en);
    clk_rs232_en = en;
    #1;
    if (a_req0_valid && a_req0_ready) hs_q.push_back(1'b0);
    if (a_req1_valid && a_req1_ready) hs_q.push_back(1'b1);
    @(posedge clk);
    #1;
    if (hs_q.size() >= hs_limit) begin
      a_req0_valid = 1'b0;
      a_req1_valid = 1'b0;
    end
  endtask

  task automatic idle3();
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
  endtask

  // Ticks T0..T9 of an instance-a frame, one tick every 4 clocks; bits[i] = tx after tick Ti.
  task automatic a_frame(output logic [9:0] bits, output logic src);
    bits = '0;
    src  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      bits[i] = a_tx;
      if (i == 0) src = a_active_src;
      idle3();
    end
  endtask

  initial begin
    logic [9:0]  bits;
    logic        src;
    logic [63:0] log_tx;
    logic [3:0]  srcs, order;
    int          lows;

    // Reset held with a request pending and ticks running
    a_req0_valid = 1'b1;
    a_req0_data  = 8'hA5;
    cyc(1'b1); cyc(1'b0); cyc(1'b1);
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_rdy0", a_req0_ready, 1'b0);
    check("rst_rdy1", a_req1_ready, 1'b0);
    check("rst_done", a_frame_done, 1'b0);
    check("rst_src", a_active_src, 1'b0);
    rst = 1'b1;
    #1;
    check("rel_rdy0", a_req0_ready, 1'b1);

    // Single byte 0xA5, STOP_BITS=1
    cyc(1'b0);
    a_req0_valid = 1'b0;
    check("held_busy", a_busy, 1'b1);
    check("held_rdy0", a_req0_ready, 1'b0);
    a_frame(bits, src);
    check("a5_bits", bits, 10'h34A);
    check("a5_src", src, 1'b0);
    check("a5_done_early", a_frame_done, 1'b0);
    cyc(1'b1);
    check("a5_done", a_frame_done, 1'b1);
    check("a5_busy_end", a_busy, 1'b0);
    check("a5_tx_end", a_tx, 1'b1);
    cyc(1'b0);
    check("a5_done_once", a_frame_done, 1'b0);
    cyc(1'b0); cyc(1'b0);

    // Handshake coincident with a tick in IDLE: no start on that tick
    a_req1_valid = 1'b1;
    a_req1_data  = 8'h3C;
    cyc(1'b1);
    a_req1_valid = 1'b0;
    check("coin_tx", a_tx, 1'b1);
    check("coin_busy", a_busy, 1'b1);
    idle3();
    a_frame(bits, src);
    check("coin_bits", bits, 10'h278);
    check("coin_src", src, 1'b1);
    cyc(1'b1);
    check("coin_done", a_frame_done, 1'b1);
    idle3();

    // Contention: both requesters held for four frames, back-to-back
    hs_q.delete();
    hs_limit     = 4;
    a_req0_data  = 8'h11;
    a_req1_data  = 8'h22;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    cyc(1'b0);
    log_tx = '0;
    srcs   = '0;
    for (int t = 0; t <= 40; t++) begin
      cyc(1'b1);
      log_tx[t] = a_tx;
      if (t % 10 == 0 && t < 40) srcs[t / 10] = a_active_src;
      if (t < 40) idle3();
    end
    order = '0;
    for (int i = 0; i < 4 && i < hs_q.size(); i++) order[i] = hs_q[i];
    check("cont_hs_count", hs_q.size(), 4);
    check("cont_order", order, 4'b1010);
    check("cont_srcs", srcs, 4'b1010);
    check("cont_tx", log_tx, {1'b1, 10'h244, 10'h222, 10'h244, 10'h222});
    check("cont_done", a_frame_done, 1'b1);
    check("cont_busy_end", a_busy, 1'b0);
    hs_limit = 1000;
    idle3();

    // STOP_BITS=2 on instance b: 0xFF then 0x00 queued
    b_req0_valid = 1'b1;
    b_req0_data  = 8'hFF;
    cyc(1'b0);
    b_req0_data  = 8'h00;
    log_tx = '0;
    for (int t = 0; t <= 22; t++) begin
      cyc(1'b1);
      log_tx[t] = b_tx;
      if (t == 10) check("sb2_done_early", b_frame_done, 1'b0);
      if (t == 11) check("sb2_done_first", b_frame_done, 1'b1);
      if (t == 0) begin
        cyc(1'b0);
        b_req0_valid = 1'b0;
        cyc(1'b0); cyc(1'b0);
      end else if (t < 22) begin
        idle3();
      end
    end
    check("sb2_tx", log_tx, {1'b1, 11'h600, 11'h7FE});
    check("sb2_done_last", b_frame_done, 1'b1);
    check("sb2_busy_end", b_busy, 1'b0);
    check("sb2_src", b_active_src, 1'b0);
    idle3();

    // Reset during data bit 3 with a second byte held
    a_req0_valid = 1'b1;
    a_req0_data  = 8'h5A;
    cyc(1'b0);
    a_req0_valid = 1'b0;
    cyc(1'b1);
    a_req1_valid = 1'b1;
    a_req1_data  = 8'h77;
    cyc(1'b0);
    a_req1_valid = 1'b0;
    cyc(1'b0); cyc(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      idle3();
    end
    check("mid_busy_pre", a_busy, 1'b1);
    rst = 1'b0;
    cyc(1'b1);
    check("mid_tx", a_tx, 1'b1);
    check("mid_busy", a_busy, 1'b0);
    rst = 1'b1;
    hs_q.delete();
    hs_limit     = 1;
    a_req0_data  = 8'hC3;
    a_req1_data  = 8'h99;
    a_req0_valid = 1'b1;
    a_req1_valid = 1'b1;
    cyc(1'b0);
    check("mid_grant", (hs_q.size() == 1) ? {63'd0, hs_q[0]} : 64'd9, 1'b0);
    hs_limit = 1000;
    a_frame(bits, src);
    check("mid_bits", bits, 10'h386);
    check("mid_src", src, 1'b0);
    cyc(1'b1);
    check("mid_done", a_frame_done, 1'b1);
    lows = 0;
    for (int i = 0; i < 12; i++) begin
      idle3();
      cyc(1'b1);
      if (a_tx == 1'b0) lows++;
    end
    check("mid_no_resend", lows, 0);
    check("mid_busy_end", a_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Two-requester RS232 transmit controller. It arbitrates byte requests from two clients round-robin into a one-entry holding register, then serializes each byte as an 8N1 or 8N2 frame. All bit timing comes from the one-cycle baud enable pulse produced by the RS232 clock generator. It sits between the memory/command logic and the TX pin, so two producers can share one serial line with back-to-back frames.

## Interface
- STOP_BITS, 1, stop bits per frame; legal values are 1 and 2.
- clk  in  1  system clock; every register is updated on its rising edge.
- rst  in  1  reset; synchronous, active-low.
- clk_rs232_en  in  1  baud tick; one-cycle pulse per bit period.
- req0_valid  in  1  requester 0 has a byte to send.
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte is accepted this cycle.
- req1_valid  in  1  requester 1 has a byte to send.
- req1_data  in  8  requester 1 byte.
- req1_ready  out  1  requester 1 byte is accepted this cycle.
- tx  out  1  serial line; idle level is high.
- busy  out  1  a frame is in progress or the holding register is full.
- active_src  out  1  requester whose frame is currently on tx.
- frame_done  out  1  one-cycle pulse when a frame's stop time completes.

## Operation
- Reset (rst=0 at a clk edge):
  - tx=1, busy=0, active_src=0, frame_done=0.
  - Holding register is emptied and the shifter state goes to IDLE.
  - Last-grant pointer is set to 1, so requester 0 wins the first contention.
  - While rst=0, req0_ready and req1_ready are forced to 0 and clk_rs232_en is ignored.
- Arbitration (combinational):
  - Readies are 0 while the holding register is full.
  - Holding register empty, only one valid: that requester gets ready=1.
  - Holding register empty, both valid: the requester not granted last gets ready=1.
  - At most one ready is high at any time.
  - Handshake is valid&&ready. On handshake, the holding register loads the data and source, and the last-grant pointer updates.
- Shifter states: IDLE, DATA, STOP. Internal counters are bit_cnt (0..8) and stop_cnt.
  - IDLE: tx=1. On a tick with the holding register full:
    - tx<=0 (start bit), shift register<=held byte, active_src<=held source.
    - Holding register is emptied, bit_cnt<=0, next state DATA.
  - DATA, on a tick with bit_cnt<8: tx<=shift[0], shift right, bit_cnt++.
  - DATA, on a tick with bit_cnt==8: tx<=1 (stop bit), stop_cnt<=0, next state STOP.
  - STOP, on a tick with stop_cnt<STOP_BITS-1: stop_cnt++.
  - STOP, on a tick with stop_cnt==STOP_BITS-1: frame_done is pulsed on the next cycle, then:
    - Holding register full: start the next frame immediately, same actions as the IDLE start.
    - Otherwise: next state IDLE, tx stays 1.
- Data is sent LSB first.
- busy = (state!=IDLE) || holding register full. busy is registered and consistent with state on the same cycle.

## Timing
- tx changes only on clk edges where clk_rs232_en=1.
- Frame ticks, with T0 as the start tick:
  - T0: start bit (tx=0).
  - T1..T8: data bits 0..7.
  - T9: stop bit begins (tx=1).
  - T(9+STOP_BITS): stop time complete; the next start bit is driven here if a byte is held.
- Handshake latency:
  - A byte accepted in IDLE starts on the first tick strictly after the handshake cycle.
  - A handshake in the same cycle as a tick does not start that tick's frame.
- Back-to-back transfer:
  - The holding register empties at the start tick, and a new handshake is possible on the next cycle.
  - A second byte accepted at any time before T(9+STOP_BITS) gives zero idle bits between frames.
- frame_done is high for exactly one cycle, the cycle after T(9+STOP_BITS).
- Reset mid-frame:
  - The frame is truncated and tx=1 from the next edge.
  - The held byte is discarded and is not retransmitted.
- Ticks arriving while in IDLE with the holding register empty have no effect.

## Test plan
- Reset: rst=0 for 3 cycles with req0_valid=1 and ticks running -> tx=1, busy=0, both readies 0; after release, req0_ready=1 on the first cycle.
- Single byte: tick every 4 cycles, STOP_BITS=1, req0 sends 0xA5 -> tx at T0..T9 is 0,1,0,1,0,0,1,0,1,1; active_src=0; frame_done pulses one cycle after T10; busy=0 from that cycle.
- Contention: both valid, req0=0x11, req1=0x22, held for 4 frames -> accepted order 0,1,0,1; each start bit falls exactly 10 ticks after the previous one; tx never idles between frames.
- STOP_BITS=2: 0xFF, then 0x00 queued -> tx low for 1 tick period, high for 10 periods, next start at T11.
- Reset mid-frame: rst=0 during data bit 3 with a second byte held -> tx=1 next edge, busy=0; after release, only newly requested bytes are sent, with requester 0 granted first.
- Coincident tick: handshake on the same cycle as a tick in IDLE -> tx stays 1 on that tick; start bit on the next tick.
